// File: rtl/capture_buffer_if.sv
// Bundled bus, sample-in, readout-out and status signals of the capture buffer.
interface capture_buffer_if #(
  parameter int BAW = 6,
  parameter int BDW = 32,
  parameter int SDW = 32,
  parameter int SEW = 2
);
  logic           bus_wready;
  logic           bus_wvalid;
  logic [BAW-1:0] bus_waddr;
  logic [BDW-1:0] bus_wdata;
  logic [3:0]     bus_wselct;

  logic           sti_tready;
  logic           sti_tvalid;
  logic [SEW-1:0] sti_tevent;
  logic [SDW-1:0] sti_tdata;

  logic           sto_tready;
  logic           sto_tvalid;
  logic [SDW-1:0] sto_tdata;
  logic           sto_tlast;

  logic [1:0]     sts_state;

  modport slave (
    output bus_wready,
    input  bus_wvalid, bus_waddr, bus_wdata, bus_wselct,
    output sti_tready,
    input  sti_tvalid, sti_tevent, sti_tdata,
    input  sto_tready,
    output sto_tvalid, sto_tdata, sto_tlast,
    output sts_state
  );

  modport master (
    input  bus_wready,
    output bus_wvalid, bus_waddr, bus_wdata, bus_wselct,
    input  sti_tready,
    output sti_tvalid, sti_tevent, sti_tdata,
    output sto_tready,
    input  sto_tvalid, sto_tdata, sto_tlast,
    input  sts_state
  );
endinterface

// File: rtl/capture_buffer.sv
// Circular pre/post-trigger sample capture with chronological stream readout.
// state  | meaning
// IDLE   | samples discarded, waiting for arm
// ARMED  | writing circular history, waiting for trigger/stop
// POST   | writing cfg_dly post-trigger samples
// READ   | streaming the last cfg_rdc+1 samples out
module capture_buffer #(
  parameter int BAW = 6,
  parameter int BDW = 32,
  parameter int SDW = 32,
  parameter int SEW = 2,
  parameter int MAW = 10
) (
  input logic                clk,
  input logic                rst,
  capture_buffer_if.slave    s_cb
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  localparam logic [MAW-1:0] L_ONE     = MAW'(1);
  localparam logic [MAW:0]   L_REM_ONE = (MAW+1)'(1);

  state_t r_state;
  state_t w_next;

  logic [MAW-1:0] r_cfg_dly;
  logic [MAW-1:0] r_cfg_rdc;
  logic [MAW-1:0] r_wp;
  logic [MAW-1:0] r_cnt;
  logic [MAW-1:0] r_rp;
  logic [MAW:0]   r_rem;

  logic [SDW-1:0] r_mem [0:(1<<MAW)-1];
  logic [SDW-1:0] r_rd_data;
  logic           r_rd_valid;
  logic           r_rd_last;
  logic [SDW-1:0] r_out_data;
  logic           r_out_valid;
  logic           r_out_last;

  logic w_wr;
  logic w_arm;
  logic w_abort;
  logic w_smp;
  logic w_mem_we;
  logic w_load_post;
  logic w_enter_read;
  logic w_issue;
  logic w_out_ready;
  logic w_rd_adv;
  logic w_last_xfer;
  logic w_unused;

  assign s_cb.bus_wready = 1'b1;
  assign s_cb.sti_tready = 1'b1;

  assign w_wr    = s_cb.bus_wvalid & s_cb.bus_wselct[0];
  assign w_arm   = w_wr & (s_cb.bus_waddr[1:0] == 2'd0) & s_cb.bus_wdata[0];
  assign w_abort = w_wr & (s_cb.bus_waddr[1:0] == 2'd0) & s_cb.bus_wdata[1];
  assign w_smp   = s_cb.sti_tvalid;

  assign w_out_ready = ~r_out_valid | s_cb.sto_tready;
  assign w_rd_adv    = r_rd_valid & w_out_ready;
  assign w_last_xfer = r_out_valid & r_out_last & s_cb.sto_tready;

  assign w_unused = &{1'b0, s_cb.bus_wselct[3:1], s_cb.bus_waddr[BAW-1:2],
                      s_cb.bus_wdata[BDW-1:MAW]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_dly <= '0;
      r_cfg_rdc <= '0;
    end else if (w_wr) begin
      if (s_cb.bus_waddr[1:0] == 2'd1) r_cfg_dly <= s_cb.bus_wdata[MAW-1:0];
      if (s_cb.bus_waddr[1:0] == 2'd2) r_cfg_rdc <= s_cb.bus_wdata[MAW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arm) w_next = ST_ARMED;
        end
        ST_ARMED: begin
          if (w_smp) begin
            if (s_cb.sti_tevent[1])                         w_next = ST_READ;
            else if (s_cb.sti_tevent[0] && r_cfg_dly == '0) w_next = ST_READ;
            else if (s_cb.sti_tevent[0])                    w_next = ST_POST;
          end
        end
        ST_POST: begin
          // cnt == 1 means this sample is the last post-trigger one
          if (w_smp && (s_cb.sti_tevent[1] || r_cnt == L_ONE)) w_next = ST_READ;
        end
        ST_READ: begin
          if (w_last_xfer) w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_mem_we = 1'b0;
    w_issue  = 1'b0;
    case (r_state)
      ST_ARMED, ST_POST: w_mem_we = w_smp & ~w_abort;
      ST_READ:           w_issue  = ~w_abort & (r_rem != '0) & (~r_rd_valid | w_rd_adv);
      default: ;
    endcase
    w_load_post  = (r_state == ST_ARMED) && (w_next == ST_POST);
    w_enter_read = (r_state != ST_READ) && (w_next == ST_READ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_mem_we) r_wp <= r_wp + L_ONE;
      if (w_load_post)                           r_cnt <= r_cfg_dly;
      else if (r_state == ST_POST && w_mem_we)   r_cnt <= r_cnt - L_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wp] <= s_cb.sti_tdata;
    if (w_issue)  r_rd_data   <= r_mem[r_rp];
  end

  // r_wp is still the pre-increment value on the READ entry edge, so
  // wp_end - (rdc+1) reduces to r_wp - rdc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rp        <= '0;
      r_rem       <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_abort) begin
      r_rem       <= '0;
      r_rd_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_enter_read) begin
        r_rp  <= r_wp - r_cfg_rdc;
        r_rem <= {1'b0, r_cfg_rdc} + L_REM_ONE;
      end else if (w_issue) begin
        r_rp  <= r_rp + L_ONE;
        r_rem <= r_rem - L_REM_ONE;
      end

      if (w_issue) begin
        r_rd_valid <= 1'b1;
        r_rd_last  <= (r_rem == L_REM_ONE);
      end else if (w_rd_adv) begin
        r_rd_valid <= 1'b0;
      end

      if (w_rd_adv) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_rd_data;
        r_out_last  <= r_rd_last;
      end else if (s_cb.sto_tready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign s_cb.sto_tvalid = r_out_valid;
  assign s_cb.sto_tdata  = r_out_data;
  assign s_cb.sto_tlast  = r_out_last;
  assign s_cb.sts_state  = r_state;

endmodule
